// File: rtl/cache_nway_if.sv
// Processor-side word bus and memory-side block bus of the N-way cache.
// The cache uses the slave modport; the environment driving it uses master.
interface cache_nway_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with true LRU per set.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module cache_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    cache_nway_if.slave  bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  perf_hit_cnt,
    output logic [31:0]  perf_miss_cnt,
    output logic [31:0]  perf_wb_cnt
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FETCH} state_t;

    state_t             state_q, state_d;
    logic [27:0]        blk_q, blk_d;
    logic [AGE_W-1:0]   way_q, way_d;
    logic [127:0]       data_q  [SETS][WAYS];
    logic [127:0]       data_d  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
    logic [AGE_W-1:0]   age_q   [SETS][WAYS];
    logic [AGE_W-1:0]   age_d   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS-1:0]    dirty_d [SETS];

    logic               req;
    logic [IDX_W-1:0]   cur_idx, blk_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [1:0]         cur_off;
    logic               hit, idle_hit, vic_found;
    logic [AGE_W-1:0]   hit_way, vic_way, lru_way;
    logic [IDX_W-1:0]   lru_idx;
    logic               lru_en;

    assign req     = bus.proc_read | bus.proc_write;
    assign cur_idx = bus.proc_addr[2 +: IDX_W];
    assign cur_tag = bus.proc_addr[29 -: TAG_W];
    assign cur_off = bus.proc_addr[1:0];
    assign blk_idx = blk_q[IDX_W-1:0];

    // Tag lookup plus victim choice: free ways first, otherwise the oldest one.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_found = 1'b0;
        vic_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!vic_found && !valid_q[cur_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = AGE_W'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[cur_idx][w] == AGE_MAX) vic_way = AGE_W'(w);
            end
        end
    end

    assign idle_hit       = hit && (state_q == S_IDLE);
    assign bus.proc_stall = req & ~idle_hit;
    assign bus.proc_rdata = idle_hit ? data_q[cur_idx][hit_way][{cur_off, 5'b0} +: 32] : 32'h0;
    assign bus.mem_write  = (state_q == S_WB) && !proc_reset;
    assign bus.mem_read   = (state_q == S_FETCH) && !proc_reset;
    assign bus.mem_addr   = bus.mem_write ? {tag_q[blk_idx][way_q], blk_idx} :
                            bus.mem_read  ? blk_q : 28'h0;
    assign bus.mem_wdata  = bus.mem_write ? data_q[blk_idx][way_q] : 128'h0;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        way_d   = way_q;
        data_d  = data_q;
        tag_d   = tag_q;
        age_d   = age_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_en  = 1'b0;
        lru_idx = cur_idx;
        lru_way = hit_way;
        case (state_q)
            S_IDLE: begin
                if (req && idle_hit) begin
                    lru_en = 1'b1;
                    if (bus.proc_write) begin
                        data_d[cur_idx][hit_way][{cur_off, 5'b0} +: 32] = bus.proc_wdata;
                        dirty_d[cur_idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    blk_d   = bus.proc_addr[29:2];
                    way_d   = vic_way;
                    state_d = (valid_q[cur_idx][vic_way] && dirty_q[cur_idx][vic_way]) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    data_d[blk_idx][way_q]  = bus.mem_rdata;
                    tag_d[blk_idx][way_q]   = blk_q[27 -: TAG_W];
                    valid_d[blk_idx][way_q] = 1'b1;
                    dirty_d[blk_idx][way_q] = 1'b0;
                    lru_en  = 1'b1;
                    lru_idx = blk_idx;
                    lru_way = way_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Touched way becomes youngest; every way younger than it ages by one.
        if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[lru_idx][w] < age_q[lru_idx][lru_way])
                    age_d[lru_idx][w] = age_q[lru_idx][w] + 1'b1;
            end
            age_d[lru_idx][lru_way] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            way_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            way_q   <= way_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            age_q   <= age_d;
        end
        data_q <= data_d;
        tag_q  <= tag_d;
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (req && idle_hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        if (req && state_q == S_IDLE && !idle_hit && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
        if (state_q == S_WB && bus.mem_ready && wb_cnt_q != 32'hFFFF_FFFF) wb_cnt_d = wb_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
    assign perf_wb_cnt   = wb_cnt_q;
`endif
endmodule
